// File: rtl/gauss_img_ram_if.sv
// Pixel read/write bus between the Gauss filter reader/writer and one image memory.
interface gauss_img_ram_if;
   localparam int unsigned CRD_W = 10;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned CNT_W = 17;
   localparam int unsigned OOB_W = 16;

   logic             rd_en;
   logic [CRD_W-1:0] rd_px;
   logic [CRD_W-1:0] rd_py;
   logic [PIX_W-1:0] rd_dt;
   logic             rd_vl;
   logic             wr_en;
   logic [CRD_W-1:0] wr_px;
   logic [CRD_W-1:0] wr_py;
   logic [PIX_W-1:0] wr_dt;
   logic [CNT_W-1:0] wr_cnt;
   logic [OOB_W-1:0] wr_oob_cnt;

   modport master (
      output rd_en, rd_px, rd_py, wr_en, wr_px, wr_py, wr_dt,
      input  rd_dt, rd_vl, wr_cnt, wr_oob_cnt
   );

   modport slave (
      input  rd_en, rd_px, rd_py, wr_en, wr_px, wr_py, wr_dt,
      output rd_dt, rd_vl, wr_cnt, wr_oob_cnt
   );
endinterface

// File: rtl/gauss_img_ram.sv
// W x H byte image memory with border-policy reads, fixed-latency read pipeline,
// write-first collision handling and saturating write counters.
module gauss_img_ram #(
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned IMG_H  = 256,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned BORDER = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   gauss_img_ram_if.slave bus
);
   localparam int unsigned XW    = $clog2(IMG_W);
   localparam int unsigned YW    = $clog2(IMG_H);
   localparam int unsigned AW    = XW + YW;
   localparam int unsigned DEPTH = IMG_W * IMG_H;
   localparam int unsigned CW    = 11;
   localparam int unsigned DW    = 8;
   localparam int unsigned CNT_W = 17;
   localparam int unsigned OOB_W = 16;

   typedef logic signed [CW-1:0] coord_t;

   localparam coord_t NX = coord_t'(CW'(IMG_W));
   localparam coord_t NY = coord_t'(CW'(IMG_H));

   function automatic coord_t sext(input logic [9:0] c);
      return coord_t'({c[9], c});
   endfunction

   function automatic logic inside_axis(input coord_t c, input coord_t n);
      return (c >= coord_t'(0)) && (c < n);
   endfunction

   // Border remap of one axis; zero policy leaves the coordinate untouched
   function automatic coord_t map_axis(input coord_t c, input coord_t n);
      coord_t m;
      m = c;
      if (BORDER == 1) begin
         if (c < coord_t'(0))  m = coord_t'(0);
         else if (c >= n)      m = n - coord_t'(1);
      end else if (BORDER == 2) begin
         if (c < coord_t'(0))  m = -c;
         else if (c >= n)      m = (n + n) - coord_t'(2) - c;
      end
      return m;
   endfunction

   logic [DW-1:0]    mem [DEPTH];
   logic             run_q;
   coord_t           rx, ry, wx, wy;
   logic             rd_img, wr_img, wr_go, wr_drop, bypass;
   logic [AW-1:0]    rd_addr, wr_addr;
   logic [DW-1:0]    rd_word;
   logic [RD_LAT-1:0] vl_q;
   logic [DW-1:0]    dt_q [RD_LAT];
   logic [CNT_W-1:0] cnt_q;
   logic [OOB_W-1:0] oob_q;

   // Coordinate decode, address build and write-first read data selection
   always_comb begin
      rx      = map_axis(sext(bus.rd_px), NX);
      ry      = map_axis(sext(bus.rd_py), NY);
      wx      = sext(bus.wr_px);
      wy      = sext(bus.wr_py);
      rd_img  = inside_axis(rx, NX) && inside_axis(ry, NY);
      wr_img  = inside_axis(wx, NX) && inside_axis(wy, NY);
      rd_addr = {ry[YW-1:0], rx[XW-1:0]};
      wr_addr = {wy[YW-1:0], wx[XW-1:0]};
      wr_go   = bus.wr_en && run_q && wr_img;
      wr_drop = bus.wr_en && run_q && !wr_img;
      bypass  = wr_go && (wr_addr == rd_addr);
      rd_word = '0;
      if (rd_img) rd_word = bypass ? bus.wr_dt : mem[rd_addr];
   end

   // Writes are held off on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_go) mem[wr_addr] <= bus.wr_dt;
   end

   // Read pipeline; data stages only load alongside a valid so rd_dt holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vl_q <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) dt_q[i] <= '0;
      end else begin
         vl_q[0] <= bus.rd_en;
         if (bus.rd_en) dt_q[0] <= rd_word;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            vl_q[i] <= vl_q[i-1];
            if (vl_q[i-1]) dt_q[i] <= dt_q[i-1];
         end
      end
   end

   // Saturating write statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         oob_q <= '0;
      end else begin
         if (wr_go && (cnt_q != '1))   cnt_q <= cnt_q + CNT_W'(1);
         if (wr_drop && (oob_q != '1)) oob_q <= oob_q + OOB_W'(1);
      end
   end

   assign bus.rd_vl      = vl_q[RD_LAT-1];
   assign bus.rd_dt      = dt_q[RD_LAT-1];
   assign bus.wr_cnt     = cnt_q;
   assign bus.wr_oob_cnt = oob_q;
endmodule

// File: tb/tb_gauss_img_ram.sv
// Randomized bench: three gauss_img_ram instances (zero/replicate/mirror, differing
// latencies) share one stimulus stream and are checked against an array-based model.
module tb_gauss_img_ram;
   localparam int N = 256;

   typedef struct packed { int due; logic [7:0] d; } exp_t;

   logic       clk, rst_n;
   logic       rd_en, wr_en;
   logic [9:0] rd_px, rd_py, wr_px, wr_py;
   logic [7:0] wr_dt;

   logic        obs_vl  [3];
   logic [7:0]  obs_dt  [3];
   logic [16:0] obs_cnt [3];
   logic [15:0] obs_oob [3];

   function automatic int lat_of(input int b);
      return (b == 1) ? 1 : (b == 2) ? 4 : 2;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      gauss_img_ram_if bus ();
      assign bus.rd_en = rd_en;
      assign bus.rd_px = rd_px;
      assign bus.rd_py = rd_py;
      assign bus.wr_en = wr_en;
      assign bus.wr_px = wr_px;
      assign bus.wr_py = wr_py;
      assign bus.wr_dt = wr_dt;
      assign obs_vl[g]  = bus.rd_vl;
      assign obs_dt[g]  = bus.rd_dt;
      assign obs_cnt[g] = bus.wr_cnt;
      assign obs_oob[g] = bus.wr_oob_cnt;
      gauss_img_ram #(
         .IMG_W (N), .IMG_H (N), .RD_LAT (lat_of(g)), .BORDER (g)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference state
   logic [7:0] mem_m [N*N];
   exp_t       exp_q [3][$];
   logic [7:0] last_dt [3];
   int         cnt_m, oob_m, cyc, n_cmp, n_bad;
   bit         ign_wr;
   int         rx, ry, wx, wy;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0h, want %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit in_img(input int x, input int y);
      return (x >= 0) && (x < N) && (y >= 0) && (y < N);
   endfunction

   function automatic int map_c(input int b, input int c);
      if (b == 1) return (c < 0) ? 0 : (c >= N) ? N - 1 : c;
      if (b == 2) return (c < 0) ? -c : (c >= N) ? 2 * N - 2 - c : c;
      return c;
   endfunction

   function automatic int ref_read(input int b, input bit wr_in);
      int mx, my;
      mx = map_c(b, rx);
      my = map_c(b, ry);
      if (!in_img(mx, my)) return 0;
      if (wr_in && (wx == mx) && (wy == my)) return int'(wr_dt);
      return int'(mem_m[my * N + mx]);
   endfunction

   task automatic set_rd(input bit en, input int x, input int y);
      rd_en = en; rx = x; ry = y;
      rd_px = 10'(x); rd_py = 10'(y);
   endtask

   task automatic set_wr(input bit en, input int x, input int y, input logic [7:0] d);
      wr_en = en; wx = x; wy = y; wr_dt = d;
      wr_px = 10'(x); wr_py = 10'(y);
   endtask

   task automatic idle();
      set_rd(1'b0, 0, 0);
      set_wr(1'b0, 0, 0, 8'h00);
   endtask

   // What the memory does with the request sampled at edge cyc
   task automatic model_edge();
      bit   wr_ok, wr_in;
      exp_t e;
      if (rst_n) begin
         wr_ok  = wr_en && !ign_wr;
         ign_wr = 1'b0;
         wr_in  = wr_ok && in_img(wx, wy);
         if (rd_en) begin
            for (int b = 0; b < 3; b++) begin
               e.due = cyc + lat_of(b);
               e.d   = 8'(ref_read(b, wr_in));
               exp_q[b].push_back(e);
            end
         end
         if (wr_in) begin
            mem_m[wy * N + wx] = wr_dt;
            if (cnt_m < 131071) cnt_m++;
         end else if (wr_ok && oob_m < 65535) begin
            oob_m++;
         end
      end
   endtask

   // Outputs visible now are what the next edge (cyc+1) samples
   task automatic check_outputs();
      exp_t e;
      logic ev;
      for (int b = 0; b < 3; b++) begin
         ev = 1'b0;
         if (exp_q[b].size() > 0 && exp_q[b][0].due == cyc + 1) begin
            e = exp_q[b].pop_front();
            ev = 1'b1;
            last_dt[b] = e.d;
         end
         check_eq($sformatf("rd b%0d", b), {obs_vl[b], obs_dt[b]}, {ev, last_dt[b]});
         check_eq($sformatf("cnt b%0d", b), {obs_cnt[b], obs_oob[b]}, {17'(cnt_m), 16'(oob_m)});
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic do_reset(input bit wr_at_release);
      rst_n = 1'b0;
      cnt_m = 0;
      oob_m = 0;
      for (int b = 0; b < 3; b++) begin
         exp_q[b].delete();
         last_dt[b] = 8'h00;
      end
      #1;
      check_outputs();
      idle();
      step();
      rst_n  = 1'b1;
      ign_wr = 1'b1;
      if (wr_at_release) set_wr(1'b1, 6, 6, 8'h77);
      step();
      idle();
   endtask

   function automatic int rnd_coord(input bit wide);
      int edges [6] = '{-255, -1, 0, 255, 256, 510};
      case ($urandom_range(0, 3))
         0:       return wide ? int'($urandom_range(0, 1023)) - 512
                              : int'($urandom_range(0, 765)) - 255;
         1:       return edges[$urandom_range(0, 5)];
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      rst_n = 1'b1;
      idle();
      cyc = 0; n_cmp = 0; n_bad = 0; cnt_m = 0; oob_m = 0; ign_wr = 1'b0;
      for (int b = 0; b < 3; b++) last_dt[b] = 8'h00;
      #2;
      do_reset(1'b0);

      // Streaming preload with (x + 2y) mod 256; counter ends at 65536
      for (int y = 0; y < N; y++)
         for (int x = 0; x < N; x++) begin
            set_wr(1'b1, x, y, 8'(x + 2 * y));
            step();
         end
      idle();

      // 256 back-to-back in-image reads
      for (int x = 0; x < N; x++) begin
         set_rd(1'b1, x, 9);
         step();
      end
      idle();
      repeat (6) step();

      // Latency and data on corner/interior pixels
      set_rd(1'b1, 0, 0);     step();
      set_rd(1'b1, 5, 3);     step();
      set_rd(1'b1, 255, 255); step();
      idle(); repeat (6) step();

      // Border policies
      set_rd(1'b1, -1, 0);    step();
      set_rd(1'b1, 256, 0);   step();
      set_rd(1'b1, -2, -255); step();
      set_rd(1'b1, 510, 510); step();
      idle(); repeat (6) step();

      // Read before write keeps old data, same-edge read sees the write
      set_rd(1'b1, 10, 20); step();
      set_wr(1'b1, 10, 20, 8'hA5); step();
      idle(); repeat (6) step();

      // Reset with reads in flight; write at the release edge is ignored
      set_rd(1'b1, 5, 3);     step();
      set_rd(1'b1, 255, 255); step();
      idle();
      do_reset(1'b1);
      set_rd(1'b1, 5, 3); step();
      set_rd(1'b1, 6, 6); step();
      idle(); repeat (6) step();

      // Out-of-image writes dropped and counted
      set_wr(1'b1, 300, 4, 8'h11); step();
      set_wr(1'b1, -1, 7, 8'h22);  step();
      set_wr(1'b1, 4, 4, 8'hC3);   step();
      idle();
      set_rd(1'b1, 4, 4); step();
      idle(); repeat (6) step();

      // Random traffic with frequent read/write address overlap
      repeat (3000) begin
         set_rd($urandom_range(0, 3) != 0, rnd_coord(1'b0), rnd_coord(1'b0));
         if ($urandom_range(0, 3) == 0)
            set_wr($urandom_range(0, 1) == 1, map_c(int'($urandom_range(0, 2)), rx),
                   map_c(int'($urandom_range(0, 2)), ry), 8'($urandom_range(0, 255)));
         else
            set_wr($urandom_range(0, 1) == 1, rnd_coord(1'b1), rnd_coord(1'b1),
                   8'($urandom_range(0, 255)));
         step();
      end
      idle();
      repeat (8) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
